// File: rtl/bus_pkg.sv
// Shared types and constants for the bus transfer sequencer.
// Holds the source-code map, the queued request record and the FSM states.
package bus_pkg;

    localparam int SRC_W      = 5;
    localparam int NUM_SRC    = 25;
    localparam int XFER_DST_W = 24;

    localparam logic [SRC_W-1:0] SRC_R0     = 5'd0;
    localparam logic [SRC_W-1:0] SRC_R1     = 5'd1;
    localparam logic [SRC_W-1:0] SRC_R2     = 5'd2;
    localparam logic [SRC_W-1:0] SRC_R3     = 5'd3;
    localparam logic [SRC_W-1:0] SRC_R4     = 5'd4;
    localparam logic [SRC_W-1:0] SRC_R5     = 5'd5;
    localparam logic [SRC_W-1:0] SRC_R6     = 5'd6;
    localparam logic [SRC_W-1:0] SRC_R7     = 5'd7;
    localparam logic [SRC_W-1:0] SRC_R8     = 5'd8;
    localparam logic [SRC_W-1:0] SRC_R9     = 5'd9;
    localparam logic [SRC_W-1:0] SRC_R10    = 5'd10;
    localparam logic [SRC_W-1:0] SRC_R11    = 5'd11;
    localparam logic [SRC_W-1:0] SRC_R12    = 5'd12;
    localparam logic [SRC_W-1:0] SRC_R13    = 5'd13;
    localparam logic [SRC_W-1:0] SRC_R14    = 5'd14;
    localparam logic [SRC_W-1:0] SRC_R15    = 5'd15;
    localparam logic [SRC_W-1:0] SRC_HI     = 5'd16;
    localparam logic [SRC_W-1:0] SRC_LO     = 5'd17;
    localparam logic [SRC_W-1:0] SRC_ZHI    = 5'd18;
    localparam logic [SRC_W-1:0] SRC_ZLO    = 5'd19;
    localparam logic [SRC_W-1:0] SRC_PC     = 5'd20;
    localparam logic [SRC_W-1:0] SRC_MDR    = 5'd21;
    localparam logic [SRC_W-1:0] SRC_MAR    = 5'd22;
    localparam logic [SRC_W-1:0] SRC_INPORT = 5'd23;
    localparam logic [SRC_W-1:0] SRC_C      = 5'd24;

    typedef struct packed {
        logic [SRC_W-1:0]      src;
        logic [XFER_DST_W-1:0] dst;
        logic [1:0]            hold;
    } xfer_req_t;

    typedef enum logic {
        IDLE,
        DRIVE
    } state_t;

endpackage

// File: rtl/xfer_fifo.sv
// Synchronous request FIFO with separate occupancy count and flush.
// Ports: clock/clear, flush, push/wr_data, pop/rd_data (head), full, empty.
module xfer_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // full is taken from the registered count, so a pop never frees a slot
    // for a push on the same edge
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Sequences queued bus transfers into one-hot source strobes and
// destination enables. Ports: clock/clear/flush, req_* handshake in,
// src_out/dst_in/xfer_done/busy out. Optional BUS_SRC_CHECK_EN adds err_src.
module bus_transfer_sequencer #(
    parameter int DEPTH   = 4,
    parameter int DST_W   = 24,
    parameter int NUM_SRC = 25
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic                      flush,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [bus_pkg::SRC_W-1:0] req_src,
    input  logic [DST_W-1:0]          req_dst,
    input  logic [1:0]                req_hold,
    output logic [NUM_SRC-1:0]        src_out,
    output logic [DST_W-1:0]          dst_in,
    output logic                      xfer_done,
`ifdef BUS_SRC_CHECK_EN
    output logic                      err_src,
`endif
    output logic                      busy
);

    import bus_pkg::*;

    xfer_req_t                    wr_req;
    xfer_req_t                    head;
    logic [$bits(xfer_req_t)-1:0] rd_word;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         pop;
    logic                         head_bad;

    state_t           state;
    state_t           state_nx;
    logic [1:0]       hold_cnt;
    logic [1:0]       hold_nx;
    logic [SRC_W-1:0] cur_src;
    logic [SRC_W-1:0] src_nx;
    logic [DST_W-1:0] cur_dst;
    logic [DST_W-1:0] dst_nx;
    logic             cur_bad;
    logic             bad_nx;

    logic [NUM_SRC-1:0] src_out_nx;
    logic [DST_W-1:0]   dst_in_nx;
    logic               done_nx;

    always_comb begin
        wr_req      = '0;
        wr_req.src  = req_src;
        wr_req.dst  = XFER_DST_W'(req_dst);
        wr_req.hold = req_hold;
    end

    assign head = xfer_req_t'(rd_word);

    xfer_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(xfer_req_t))
    ) u_fifo (
        .clock   (clock),
        .clear   (clear),
        .flush   (flush),
        .push    (req_valid),
        .pop     (pop),
        .wr_data (wr_req),
        .rd_data (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign req_ready = !fifo_full;
    assign busy      = (state == DRIVE) || !fifo_empty;

`ifdef BUS_SRC_CHECK_EN
    // an illegal code is retired in a single silent cycle
    assign head_bad = (int'(head.src) >= NUM_SRC);
`else
    assign head_bad = 1'b0;
`endif

    // state register plus registered outputs
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            cur_src   <= '0;
            cur_dst   <= '0;
            cur_bad   <= 1'b0;
            src_out   <= '0;
            dst_in    <= '0;
            xfer_done <= 1'b0;
        end else begin
            state     <= state_nx;
            hold_cnt  <= hold_nx;
            cur_src   <= src_nx;
            cur_dst   <= dst_nx;
            cur_bad   <= bad_nx;
            src_out   <= src_out_nx;
            dst_in    <= dst_in_nx;
            xfer_done <= done_nx;
        end
    end

    // next state: pop on IDLE or on the last drive cycle
    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        src_nx   = cur_src;
        dst_nx   = cur_dst;
        bad_nx   = cur_bad;
        pop      = 1'b0;
        if (flush) begin
            state_nx = IDLE;
            hold_nx  = '0;
            bad_nx   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    pop = !fifo_empty;
                end
                DRIVE: begin
                    if (hold_cnt != 2'd0) begin
                        hold_nx = hold_cnt - 2'd1;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        bad_nx   = 1'b0;
                    end
                end
            endcase
            if (pop) begin
                state_nx = DRIVE;
                src_nx   = head.src;
                dst_nx   = DST_W'(head.dst);
                hold_nx  = head_bad ? 2'd0 : head.hold;
                bad_nx   = head_bad;
            end
        end
    end

    // outputs are computed from the next state so they register in step
    always_comb begin
        src_out_nx = '0;
        dst_in_nx  = '0;
        done_nx    = 1'b0;
        if (state_nx == DRIVE && !bad_nx) begin
            if (int'(src_nx) < NUM_SRC) begin
                src_out_nx = NUM_SRC'(1) << src_nx;
            end
            if (hold_nx == 2'd0) begin
                dst_in_nx = dst_nx;
                done_nx   = 1'b1;
            end
        end
    end

`ifdef BUS_SRC_CHECK_EN
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            err_src <= 1'b0;
        end else if (flush) begin
            err_src <= 1'b0;
        end else if (pop && head_bad) begin
            err_src <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Self-checking bench for bus_transfer_sequencer.
// Reference model: per-request start/end cycle schedule.
module tb_bus_transfer_sequencer;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        clear;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_src;
    logic [23:0] req_dst;
    logic [1:0]  req_hold;
    logic [24:0] src_out;
    logic [23:0] dst_in;
    logic        xfer_done;
    logic        busy;
`ifdef BUS_SRC_CHECK_EN
    logic        err_src;
`endif

    typedef struct {
        int          s;
        int          last;
        logic [4:0]  src;
        logic [23:0] dst;
        bit          bad;
    } ent_t;

    ent_t q[$];
    int   errors    = 0;
    int   checks    = 0;
    int   cyc       = 0;
    int   prev_last = 0;
    int   done_seen = 0;
    bit   err_m     = 1'b0;

    bus_transfer_sequencer dut (
        .clock     (clock),
        .clear     (clear),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .req_hold  (req_hold),
        .src_out   (src_out),
        .dst_in    (dst_in),
        .xfer_done (xfer_done),
`ifdef BUS_SRC_CHECK_EN
        .err_src   (err_src),
`endif
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // requests accepted but not yet popped at cycle c
    function automatic int m_count(input int c);
        int n;
        n = 0;
        foreach (q[i]) if (q[i].s > c) n++;
        return n;
    endfunction

    task automatic check_outputs();
        logic [31:0] es;
        logic [31:0] ed;
        bit          edn;
        bit          eb;
        es  = '0;
        ed  = '0;
        edn = 1'b0;
        eb  = 1'b0;
        foreach (q[i]) begin
            if (q[i].last >= cyc) eb = 1'b1;
            if (q[i].bad && q[i].s <= cyc) err_m = 1'b1;
            if (q[i].s <= cyc && cyc <= q[i].last && !q[i].bad) begin
                if (q[i].src < 5'd25) es = 32'd1 << q[i].src;
                if (cyc == q[i].last) begin
                    ed  = 32'(q[i].dst);
                    edn = 1'b1;
                end
            end
        end
        check("src_out", 32'(src_out), es);
        check("dst_in", 32'(dst_in), ed);
        check("xfer_done", 32'(xfer_done), 32'(edn));
        check("busy", 32'(busy), 32'(eb));
        check("onehot", 32'($countones(src_out) <= 1), 32'd1);
`ifdef BUS_SRC_CHECK_EN
        check("err_src", 32'(err_src), 32'(err_m));
`endif
        if (xfer_done === 1'b1) done_seen++;
        while (q.size() > 0 && q[0].last < cyc) void'(q.pop_front());
    endtask

    task automatic tick(input bit v, input logic [4:0] s,
                        input logic [23:0] d, input logic [1:0] h,
                        input bit fl, output bit acc);
        bit   rdy;
        bit   bad;
        ent_t e;
        req_valid = v;
        req_src   = s;
        req_dst   = d;
        req_hold  = h;
        flush     = fl;
        #1;
        rdy = (m_count(cyc) < DEPTH);
        check("req_ready", 32'(req_ready), 32'(rdy));
        acc = v && rdy && !fl;
        @(posedge clock);
        cyc++;
        if (fl) begin
            q.delete();
            prev_last = cyc;
            err_m     = 1'b0;
        end else if (acc) begin
            bad = 1'b0;
`ifdef BUS_SRC_CHECK_EN
            bad = (s >= 5'd25);
`endif
            e.s    = (cyc + 1 > prev_last + 1) ? cyc + 1 : prev_last + 1;
            e.last = e.s + (bad ? 0 : int'(h));
            e.src  = s;
            e.dst  = d;
            e.bad  = bad;
            q.push_back(e);
            prev_last = e.last;
        end
        @(negedge clock);
        req_valid = 1'b0;
        flush     = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) tick(1'b0, 5'd0, 24'd0, 2'd0, 1'b0, a);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        #1;
        check("clr_src_out", 32'(src_out), 32'd0);
        check("clr_dst_in", 32'(dst_in), 32'd0);
        check("clr_done", 32'(xfer_done), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_ready", 32'(req_ready), 32'd1);
`ifdef BUS_SRC_CHECK_EN
        check("clr_err", 32'(err_src), 32'd0);
`endif
        q.delete();
        prev_last = cyc;
        err_m     = 1'b0;
        #1;
        clear = 1'b0;
    endtask

    initial begin
        bit          a;
        int          d0;
        int          nacc;
        bit          saw_full;
        logic [4:0]  rs;
        logic [1:0]  holds4 [4];
        logic [4:0]  srcs4  [4];
        req_valid = 1'b0;
        req_src   = '0;
        req_dst   = '0;
        req_hold  = '0;
        flush     = 1'b0;
        clear     = 1'b0;
        do_clear();

        // single PC transfer
        d0 = done_seen;
        tick(1'b1, 5'd20, 24'h000001, 2'd0, 1'b0, a);
        idle(3);
        check("single_done_cnt", 32'(done_seen - d0), 32'd1);

        // four back-to-back with holds 0,2,0,1
        holds4 = '{2'd0, 2'd2, 2'd0, 2'd1};
        srcs4  = '{5'd3, 5'd16, 5'd7, 5'd24};
        d0 = done_seen;
        for (int i = 0; i < 4; i++)
            tick(1'b1, srcs4[i], 24'h10 << i, holds4[i], 1'b0, a);
        idle(8);
        check("four_done_cnt", 32'(done_seen - d0), 32'd4);

        // six requests with valid held high
        nacc     = 0;
        saw_full = 1'b0;
        for (int n = 0; n < 40 && nacc < 6; n++) begin
            tick(1'b1, 5'(nacc + 8), 24'(nacc + 1) << 4, 2'd3, 1'b0, a);
            if (a) nacc++;
            if (req_ready === 1'b0) saw_full = 1'b1;
        end
        check("six_accepted", 32'(nacc), 32'd6);
        check("ready_dropped", 32'(saw_full), 32'd1);
        idle(26);

        // clear during a hold=3 transfer at hold_cnt 2
        tick(1'b1, 5'd9, 24'hABCDEF, 2'd3, 1'b0, a);
        idle(2);
        do_clear();
        d0 = done_seen;
        idle(4);
        check("clr_no_done", 32'(done_seen - d0), 32'd0);
        tick(1'b1, 5'd1, 24'h800000, 2'd1, 1'b0, a);
        idle(4);
        check("post_clr_done", 32'(done_seen - d0), 32'd1);

        // flush with one active transfer and three queued
        tick(1'b1, 5'd11, 24'h000F00, 2'd3, 1'b0, a);
        for (int i = 0; i < 3; i++)
            tick(1'b1, 5'(12 + i), 24'h1, 2'd2, 1'b0, a);
        tick(1'b1, 5'd2, 24'h2, 2'd0, 1'b1, a);
        check("flush_busy", 32'(busy), 32'd0);
        d0 = done_seen;
        idle(6);
        check("flush_no_done", 32'(done_seen - d0), 32'd0);

        // out-of-range source code followed by a legal one
        d0 = done_seen;
        tick(1'b1, 5'd27, 24'h000042, 2'd0, 1'b0, a);
        tick(1'b1, 5'd5, 24'h000084, 2'd0, 1'b0, a);
        idle(4);
`ifdef BUS_SRC_CHECK_EN
        check("bad_src_done", 32'(done_seen - d0), 32'd1);
`else
        check("bad_src_done", 32'(done_seen - d0), 32'd2);
`endif

        // randomized traffic against the schedule model
        for (int n = 0; n < 400; n++) begin
            rs = ($urandom % 8 == 0) ? 5'($urandom_range(25, 31))
                                     : 5'($urandom_range(0, 24));
            tick(($urandom % 10) < 6, rs, 24'($urandom),
                 2'($urandom_range(0, 3)), ($urandom % 40) == 0, a);
            if ($urandom % 90 == 0) do_clear();
        end
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
